// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of the 8-entry FIFO between two producers.
//   Round-robin arbitration, one write in flight at a time. Each write is
//   confirmed from the FIFO wr_ack/wr_err response; rejected writes are
//   retried up to MAX_RETRY attempts before the requester gets an err pulse.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   req0/req1, din0/din1    : producer level requests and data
//   done0/done1, err0/err1  : one-cycle completion / abandon pulses
//   fifo_wr_en, fifo_din    : write strobe and data towards the FIFO
//   fifo_full, fifo_wr_ack,
//   fifo_wr_err             : FIFO status and write response
//   busy, owner             : transaction in progress / current or last owner
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  input  logic                  fifo_full,
  input  logic                  fifo_wr_ack,
  input  logic                  fifo_wr_err,
  output logic                  busy,
  output logic                  owner
);

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_ISSUE = 3'b001;
  localparam logic [2:0] S_RESP  = 3'b010;
  localparam logic [2:0] S_HOLD  = 3'b011;
  localparam logic [2:0] S_DONE  = 3'b100;

  localparam logic [2:0] C_MAX_RETRY = 3'(MAX_RETRY);

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic                  r_rr;
  logic                  r_owner;
  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_retry;
  logic                  r_err;

  logic                  w_grant;
  logic                  w_winner;
  logic                  w_reject;
  logic [2:0]            w_retry_inc;
  logic                  w_retry_hit;

  // A new transaction may start only when someone asks and the FIFO has room.
  assign w_grant     = (req0 | req1) & ~fifo_full;
  // Contention goes to the round-robin pointer; otherwise the sole requester.
  assign w_winner    = (req0 & req1) ? r_rr : req1;
  // Ack wins over err (both set is illegal); silence counts as a reject.
  assign w_reject    = fifo_wr_err | ~fifo_wr_ack;
  // Saturating increment so a misconfigured compare can never wrap to zero.
  assign w_retry_inc = (r_retry == 3'b111) ? 3'b111 : (r_retry + 3'd1);
  assign w_retry_hit = (w_retry_inc == C_MAX_RETRY);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: w_next_state = S_RESP;
      S_RESP: begin
        if (fifo_wr_ack) begin
          w_next_state = S_DONE;
        end else if (w_reject && w_retry_hit) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (fifo_full) begin
          w_next_state = S_HOLD;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Transaction datapath: latched data/owner, retry count, result, rr pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_owner <= 1'b0;
      r_retry <= 3'd0;
      r_err   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_data  <= w_winner ? din1 : din0;
            r_owner <= w_winner;
            r_retry <= 3'd0;
            r_err   <= 1'b0;
          end
        end
        S_RESP: begin
          if (!fifo_wr_ack && w_reject) begin
            r_retry <= w_retry_inc;
          end
          r_err <= ~fifo_wr_ack & w_reject & w_retry_hit;
        end
        S_DONE:  r_rr <= ~r_owner;
        default: r_rr <= r_rr;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    fifo_wr_en = (r_state == S_ISSUE);
    fifo_din   = r_data;
    busy       = (r_state != S_IDLE);
    owner      = r_owner;
    done0      = 1'b0;
    done1      = 1'b0;
    err0       = 1'b0;
    err1       = 1'b0;
    if (r_state == S_DONE) begin
      done0 = ~r_err & ~r_owner;
      done1 = ~r_err &  r_owner;
      err0  =  r_err & ~r_owner;
      err1  =  r_err &  r_owner;
    end else begin
      done0 = 1'b0;
    end
  end

endmodule
